lsu_mem_ctrl: RTL and testbench
===============================

// Module: lsu_mem_ctrl
// PURPOSE
// - Load/store initiator for the word-organised data memory (active-low MemRW: 1 = read, 0 = write).
// - Accepts byte/half/word requests from the pipeline MEM stage using byte addresses.
// - Drives the memory's word-index address; loads return sign- or zero-extended data.
// - Sub-word stores run as read-modify-write, since the memory has no byte enables.
// PARAMETERS
// - DEPTH   64  number of 32-bit words in the data memory
// - AW      6   word-index width, equal to clog2(DEPTH)
// PORTS
// - clk            in   1   rising-edge clock
// - rst            in   1   asynchronous reset, active-high
// - req_valid      in   1   request present
// - req_ready      out  1   controller can accept a request (high only in IDLE)
// - req_we         in   1   1 = store, 0 = load
// - req_size       in   2   00 = byte, 01 = half, 10 = word, 11 = illegal
// - req_unsigned   in   1   loads only: zero-extend (LBU/LHU)
// - req_addr       in   32  byte address
// - req_wdata      in   32  store data, right-aligned
// - resp_valid     out  1   single-cycle response pulse
// - resp_err       out  1   valid with resp_valid: misaligned, illegal size or out of range
// - resp_rdata     out  32  load result, extended; 0 for stores and errors
// - mem_rw         out  1   to memory MemRW; 1 = read (idle), 0 = write
// - mem_addr       out  32  word index = {zeros, req_addr[AW+1:2]}
// - mem_wdata      out  32  to memory Write_data
// - mem_rdata      in   32  from memory MemData_out (combinational read)
// BEHAVIOUR
// - Reset state: IDLE; req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_rw=1, mem_addr=0, mem_wdata=0.
// - mem_rw is 1 in every state except WR. The memory writes on any cycle with MemRW=0, so a stray 0 is a bug.
// - Accept: req_valid & req_ready at a rising edge. On accept, latch we, size, unsigned, addr and wdata.
// - FSM states: IDLE, ACC, WR, RESP.
// - IDLE -> RESP with err=1 on: size=11, half with addr[0]=1, word with addr[1:0]!=0, or range fault (see CONFIGURATION).
//   - No memory write occurs on any error.
// - IDLE -> ACC on any other accepted request.
// - ACC, load: mem_rw=1. Capture mem_rdata lane-selected by addr[1:0] and extended per size/unsigned. -> RESP.
// - ACC, word store: mem_rw=0, mem_wdata=wdata (the write commits at the edge leaving ACC). -> RESP.
// - ACC, byte/half store: mem_rw=1. Latch mem_rdata into the merge register. -> WR.
// - WR: mem_rw=0. mem_wdata = merge word with lane addr[1:0] replaced by wdata[7:0] or wdata[15:0]. -> RESP.
// - RESP: resp_valid=1 for exactly 1 cycle, then -> IDLE.
//   - resp_rdata/resp_err hold their values until the next response.
//   - A new request may be accepted on the cycle after RESP.
// - Latency from accept edge to resp_valid high:
//   - load and word store: 2 cycles
//   - sub-word store: 3 cycles
//   - error: 1 cycle
// - Lane selection:
//   - byte lane k: bits [8k+7:8k], k = addr[1:0]
//   - half lane: bits [31:16] if addr[1]=1, else [15:0]
// - Extension: sign-extend from bit 7 or 15 unless unsigned. Word loads are passed unchanged.
// - Requests arriving while not in IDLE are not accepted; the requester holds req_* stable until accepted.
// - Reset mid-operation (including in WR): return immediately to reset values, mem_rw=1. A partially done RMW is abandoned with no write.
// CONFIGURATION
// - LSU_BOUNDS_CHECK_EN defined:
//   - If req_addr[31:AW+2] != 0 or word index >= DEPTH, the request completes as an error: resp_err=1, no memory access.
// - LSU_BOUNDS_CHECK_EN undefined:
//   - No range fault; upper address bits are ignored.
//   - mem_addr = addr[AW+1:2], so the access wraps modulo DEPTH.
// TESTING
// - Reset then idle 10 cycles -> mem_rw=1 every cycle, resp_valid=0, req_ready=1.
// - SW 0xDEADBEEF @0x10, then LW @0x10 -> mem_addr=4, one mem_rw=0 cycle, load returns 0xDEADBEEF, each with latency 2.
// - After the above: SB 0x7A @0x11 -> 3-cycle latency, word becomes 0xDEAD7AEF. Then LB @0x11 -> 0x0000007A; LB @0x13 -> 0xFFFFFFDE; LBU @0x13 -> 0x000000DE.
// - SH 0x1234 @0x12 -> word becomes 0x12347AEF. Then LH @0x12 -> 0x00001234; LHU @0x10 -> 0x00007AEF.
// - LW @0x11, SH @0x13, size=11 -> each gives resp_err=1 after 1 cycle, no mem_rw=0 cycle, memory unchanged.
// - Range check, LW @0x100:
//   - with LSU_BOUNDS_CHECK_EN: resp_err=1.
//   - without it: mem_addr=0 (wrap), returns word 0.
// - Assert rst during the WR cycle of SB @0x20 -> mem_rw=1 immediately, word 8 unchanged.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store initiator for a word-organised data memory.
//
// The MEM stage issues byte/half/word requests with byte addresses. The
// controller drives the memory's word index. Loads return data that is
// lane-selected and then sign- or zero-extended. The memory has no byte
// enables, so sub-word stores run as read-modify-write.
//
// The memory writes on every cycle with mem_rw=0. For that reason mem_rw
// is a registered output that drops to 0 only for the single ACC cycle of
// a word store and for the WR cycle of a sub-word store.
//
// Optional feature: define LSU_BOUNDS_CHECK_EN to turn out-of-range
// addresses into error responses. When it is undefined, the upper address
// bits are ignored and the word index wraps modulo DEPTH.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   req_valid/ready request handshake; req_ready is high only in IDLE
//   req_we          1 = store, 0 = load
//   req_size        00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned    zero-extend loads
//   req_addr        byte address
//   req_wdata       right-aligned store data
//   resp_valid      one-cycle response pulse
//   resp_err        misaligned / illegal size / out of range
//   resp_rdata      extended load data; 0 for stores and errors
//   mem_rw          1 = read, 0 = write
//   mem_addr        word index
//   mem_wdata       write data to memory
//   mem_rdata       combinational read data from memory

module lsu_mem_ctrl #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic        mem_rw,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_X = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    // Fields of the accepted request
    logic        we_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [1:0]  lane_q;
    logic [31:0] wdata_q;

    // Next values of the registered outputs
    logic        req_ready_d;
    logic        resp_valid_d;
    logic        resp_err_d;
    logic [31:0] resp_rdata_d;
    logic        mem_rw_d;
    logic [31:0] mem_addr_d;
    logic [31:0] mem_wdata_d;

    logic        accept_c;
    logic        align_err_c;
    logic        range_err_c;
    logic        req_err_c;
    logic [31:0] load_c;
    logic [31:0] merge_c;

    assign accept_c = req_valid & req_ready;

    // Request checks on the incoming request, evaluated in IDLE
    always_comb begin
        align_err_c = 1'b0;
        case (req_size)
            SZ_H:    align_err_c = req_addr[0];
            SZ_W:    align_err_c = (req_addr[1:0] != 2'b00);
            SZ_X:    align_err_c = 1'b1;
            default: align_err_c = 1'b0;
        endcase
    end

`ifdef LSU_BOUNDS_CHECK_EN
    // Out-of-range address: upper bits must be zero and the index must be below DEPTH
    assign range_err_c = (req_addr[31:AW+2] != '0) ||
                         ({1'b0, req_addr[AW+1:2]} >= (AW+1)'(DEPTH));
`else
    // The upper bits are ignored, so the index wraps modulo DEPTH
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:AW+2];
    assign range_err_c    = 1'b0;
`endif

    assign req_err_c = align_err_c | range_err_c;

    // Load path: pick the lane, then extend it
    always_comb begin
        logic [31:0] sh;
        sh     = 32'h0;
        load_c = mem_rdata;
        case (size_q)
            SZ_B: begin
                sh     = mem_rdata >> {lane_q, 3'b000};
                load_c = uns_q ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            end
            SZ_H: begin
                sh     = mem_rdata >> {lane_q[1], 4'b0000};
                load_c = uns_q ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            end
            default: load_c = mem_rdata;
        endcase
    end

    // Store merge: replace the addressed lane of the word read in ACC
    always_comb begin
        logic [31:0] mask;
        logic [31:0] ins;
        if (size_q == SZ_B) begin
            mask = 32'h0000_00FF << {lane_q, 3'b000};
            ins  = {24'h0, wdata_q[7:0]} << {lane_q, 3'b000};
        end else begin
            mask = 32'h0000_FFFF << {lane_q[1], 4'b0000};
            ins  = {16'h0, wdata_q[15:0]} << {lane_q[1], 4'b0000};
        end
        merge_c = (mem_rdata & ~mask) | ins;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept_c) state_next = req_err_c ? RESP : ACC;
            ACC:  state_next = (we_q && (size_q != SZ_W)) ? WR : RESP;
            WR:   state_next = RESP;
            RESP: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output next values; the response fields change only on entry to RESP
    always_comb begin
        req_ready_d  = (state_next == IDLE);
        resp_valid_d = (state_next == RESP);
        resp_err_d   = resp_err;
        resp_rdata_d = resp_rdata;
        mem_rw_d     = 1'b1;
        mem_addr_d   = mem_addr;
        mem_wdata_d  = mem_wdata;
        case (state)
            IDLE: begin
                if (accept_c) begin
                    if (req_err_c) begin
                        resp_err_d   = 1'b1;
                        resp_rdata_d = 32'h0;
                    end else begin
                        mem_addr_d = 32'(req_addr[AW+1:2]);
                        // A word store writes during ACC itself
                        if (req_we && (req_size == SZ_W)) begin
                            mem_rw_d    = 1'b0;
                            mem_wdata_d = req_wdata;
                        end
                    end
                end
            end
            ACC: begin
                if (!we_q) begin
                    resp_err_d   = 1'b0;
                    resp_rdata_d = load_c;
                end else if (size_q == SZ_W) begin
                    resp_err_d   = 1'b0;
                    resp_rdata_d = 32'h0;
                end else begin
                    // mem_wdata serves as the merge register for the WR cycle
                    mem_rw_d    = 1'b0;
                    mem_wdata_d = merge_c;
                end
            end
            WR: begin
                resp_err_d   = 1'b0;
                resp_rdata_d = 32'h0;
            end
            default: ;
        endcase
    end

    // Output and request registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'h0;
            mem_rw     <= 1'b1;
            mem_addr   <= 32'h0;
            mem_wdata  <= 32'h0;
            we_q       <= 1'b0;
            size_q     <= SZ_B;
            uns_q      <= 1'b0;
            lane_q     <= 2'b00;
            wdata_q    <= 32'h0;
        end else begin
            req_ready  <= req_ready_d;
            resp_valid <= resp_valid_d;
            resp_err   <= resp_err_d;
            resp_rdata <= resp_rdata_d;
            mem_rw     <= mem_rw_d;
            mem_addr   <= mem_addr_d;
            mem_wdata  <= mem_wdata_d;
            if (accept_c) begin
                we_q    <= req_we;
                size_q  <= req_size;
                uns_q   <= req_unsigned;
                lane_q  <= req_addr[1:0];
                wdata_q <= req_wdata;
            end
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Testbench for lsu_mem_ctrl. It attaches a word memory to the DUT and keeps
// a byte-addressed reference memory that serves as the expected model.
module tb_lsu_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic        mem_rw;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;

`ifdef LSU_BOUNDS_CHECK_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    logic [31:0] dmem  [0:63];
    logic [7:0]  ref_b [0:255];

    always #5 clk = ~clk;

    lsu_mem_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
        .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Memory with a combinational read; it writes on every edge with mem_rw=0
    assign mem_rdata = dmem[mem_addr[5:0]];
    always @(posedge clk) begin
        if (mem_rw !== 1'b1) begin
            dmem[mem_addr[5:0]] <= mem_wdata;
            wr_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int idx);
        return {ref_b[4*idx+3], ref_b[4*idx+2], ref_b[4*idx+1], ref_b[4*idx]};
    endfunction

    // Expected outcome of one request, built from the memory's byte view
    task automatic model(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic err, output logic [31:0] rdata,
                         output int lat, output int nwr);
        int nb;
        int a;
        logic [31:0] v;
        err = (size == 2'd3) || (size == 2'd1 && addr[0]) ||
              (size == 2'd2 && addr[1:0] != 2'd0) || (BOUNDS && addr[31:8] != 24'd0);
        nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        a  = int'(addr[7:0]);
        rdata = 32'h0;
        if (err) begin
            lat = 1; nwr = 0;
        end else if (we) begin
            for (int i = 0; i < nb; i++) ref_b[a+i] = wdata[8*i +: 8];
            lat = (nb == 4) ? 2 : 3;
            nwr = 1;
        end else begin
            v = 32'h0;
            for (int i = 0; i < nb; i++) v[8*i +: 8] = ref_b[a+i];
            if (!uns && nb == 1) v = {{24{v[7]}}, v[7:0]};
            if (!uns && nb == 2) v = {{16{v[15]}}, v[15:0]};
            rdata = v;
            lat = 2; nwr = 0;
        end
    endtask

    // One request: drive it, wait for the response, compare with the model
    task automatic do_req(input string tag, input logic we, input logic [1:0] size,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
        logic        e_err;
        logic [31:0] e_rd;
        int          e_lat;
        int          e_nwr;
        int          n;
        int          lat;
        int          w0;
        model(we, size, uns, addr, wdata, e_err, e_rd, e_lat, e_nwr);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = size;
        req_unsigned = uns; req_addr = addr; req_wdata = wdata;
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        check({tag, "_ready"}, 32'(req_ready), 32'd1);
        w0 = wr_cnt;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        lat = 1;
        if (!e_err) check({tag, "_addr"}, mem_addr, 32'(addr[7:2]));
        while (resp_valid !== 1'b1 && lat < 8) begin @(negedge clk); lat++; end
        check({tag, "_valid"}, 32'(resp_valid), 32'd1);
        check({tag, "_lat"}, 32'(lat), 32'(e_lat));
        check({tag, "_err"}, 32'(resp_err), 32'(e_err));
        check({tag, "_rdata"}, resp_rdata, e_rd);
        check({tag, "_writes"}, 32'(wr_cnt - w0), 32'(e_nwr));
        @(negedge clk);
        check({tag, "_pulse"}, 32'(resp_valid), 32'd0);
        check({tag, "_hold"}, resp_rdata, e_rd);
    endtask

    initial begin
        int w0;
        logic [31:0] a;
        logic [1:0]  sz;
        for (int i = 0; i < 64; i++) dmem[i] <= 32'h0;
        for (int i = 0; i < 256; i++) ref_b[i] = 8'h0;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;

        // Values held during reset
        @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_valid", 32'(resp_valid), 32'd0);
        check("rst_err", 32'(resp_err), 32'd0);
        check("rst_rdata", resp_rdata, 32'h0);
        check("rst_mem_rw", 32'(mem_rw), 32'd1);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Idle for 10 cycles
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_mem_rw", 32'(mem_rw), 32'd1);
            check("idle_valid", 32'(resp_valid), 32'd0);
            check("idle_ready", 32'(req_ready), 32'd1);
        end
        check("idle_writes", 32'(wr_cnt), 32'd0);

        // Directed sequence
        do_req("sw10", 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
        check("sw10_word", dmem[4], 32'hDEADBEEF);
        do_req("lw10", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        do_req("sb11", 1'b1, 2'd0, 1'b0, 32'h11, 32'h7A);
        check("sb11_word", dmem[4], 32'hDEAD7AEF);
        do_req("lb11", 1'b0, 2'd0, 1'b0, 32'h11, 32'h0);
        do_req("lb13", 1'b0, 2'd0, 1'b0, 32'h13, 32'h0);
        do_req("lbu13", 1'b0, 2'd0, 1'b1, 32'h13, 32'h0);
        check("lbu13_const", resp_rdata, 32'h000000DE);
        do_req("sh12", 1'b1, 2'd1, 1'b0, 32'h12, 32'h1234);
        check("sh12_word", dmem[4], 32'h12347AEF);
        do_req("lh12", 1'b0, 2'd1, 1'b0, 32'h12, 32'h0);
        do_req("lhu10", 1'b0, 2'd1, 1'b1, 32'h10, 32'h0);
        check("lhu10_const", resp_rdata, 32'h00007AEF);
        do_req("lw11", 1'b0, 2'd2, 1'b0, 32'h11, 32'h0);
        do_req("sh13", 1'b1, 2'd1, 1'b0, 32'h13, 32'hFFFF);
        do_req("sz11", 1'b1, 2'd3, 1'b0, 32'h10, 32'h0);
        check("err_word", dmem[4], 32'h12347AEF);
        do_req("lw100", 1'b0, 2'd2, 1'b0, 32'h100, 32'h0);

        // Reset asserted during the WR cycle of SB @0x20
        w0 = wr_cnt;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = 32'h20; req_wdata = 32'h55;
        check("rmw_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rmw_wr_cycle", 32'(mem_rw), 32'd0);
        rst = 1'b1;
        #1;
        check("rmw_rst_mem_rw", 32'(mem_rw), 32'd1);
        check("rmw_rst_ready", 32'(req_ready), 32'd1);
        check("rmw_rst_valid", 32'(resp_valid), 32'd0);
        check("rmw_rst_addr", mem_addr, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        check("rmw_rst_writes", 32'(wr_cnt - w0), 32'd0);
        check("rmw_rst_word8", dmem[8], ref_word(8));

        // Random requests
        for (int i = 0; i < 40; i++) begin
            a  = 32'($urandom_range(0, 255));
            sz = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin
                if (sz == 2'd1) a[0] = 1'b0;
                if (sz == 2'd2) a[1:0] = 2'b00;
            end
            if ($urandom_range(0, 7) == 0) a[31:8] = 24'($urandom);
            do_req("rnd", 1'($urandom), sz, 1'($urandom), a, $urandom);
        end

        // Final memory image against the reference
        for (int i = 0; i < 64; i++) check("final_mem", dmem[i], ref_word(i));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
